syn_accum: RTL and testbench

SYN_ACCUM -- requirements
Module: syn_accum

---
 rtl/syn_accum.sv | 139 +++++++++++++
 tb/tb_syn_accum.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/syn_accum.sv
// ----------------------------------------------------------------------------
// syn_accum -- synaptic current accumulator for one postsynaptic neuron.
//
// On start, the presynaptic spike vector and the bias are latched. The block
// then scans all N_PRE inputs, one per cycle. For every input that spiked it
// reads that synapse's weight, adds it to the accumulator and saturates the
// sum. The result goes out on network_input with a one-cycle valid pulse. The
// latency is fixed and does not depend on how many inputs spiked.
//
// Ports
//   clk            in   rising-edge clock
//   rst            in   synchronous reset, active low
//   start          in   begin an accumulation (ignored while busy)
//   spk_vec        in   [N_PRE] presynaptic spikes, bit i = neuron i fired
//   bias           in   signed [WIDTH] initial accumulator value
//   w_en           out  weight memory read enable
//   w_addr         out  [ADDR_WIDTH] weight memory read address
//   w_rdata        in   signed [W_WIDTH] weight, valid one cycle after w_en
//   network_input  out  signed [WIDTH] accumulated current
//   valid          out  one-cycle pulse marking a new network_input
//   busy           out  high whenever not idle
// ----------------------------------------------------------------------------
module syn_accum #(
    parameter int N_PRE      = 64,
    parameter int ADDR_WIDTH = 6,
    parameter int W_WIDTH    = 8,
    parameter int WIDTH      = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [N_PRE-1:0]             spk_vec,
    input  logic signed [WIDTH-1:0]      bias,
    output logic                         w_en,
    output logic [ADDR_WIDTH-1:0]        w_addr,
    input  logic signed [W_WIDTH-1:0]    w_rdata,
    output logic signed [WIDTH-1:0]      network_input,
    output logic                         valid,
    output logic                         busy
);

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(N_PRE - 1);
    localparam logic signed [WIDTH-1:0] ACC_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] ACC_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    state_t                  state_q, state_d;
    logic [N_PRE-1:0]        spk_q, spk_d;
    logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
    logic                    pend_q, pend_d;
    logic signed [WIDTH-1:0] acc_q, acc_d;
    logic signed [WIDTH-1:0] ni_q, ni_d;
    logic                    valid_q, valid_d;

    logic signed [WIDTH-1:0] w_ext;
    logic signed [WIDTH-1:0] sum;
    logic signed [WIDTH-1:0] acc_sat;

    // Read requests are issued only while scanning, one address per cycle.
    assign w_en   = (state_q == SCAN) && spk_q[idx_q];
    assign w_addr = (state_q == SCAN) ? idx_q : '0;
    assign busy   = (state_q != IDLE);

    assign network_input = ni_q;
    assign valid         = valid_q;

    // Saturating add. It can overflow only when both operands have the same
    // sign and the wrapped sum has the other sign.
    assign w_ext = {{(WIDTH-W_WIDTH){w_rdata[W_WIDTH-1]}}, w_rdata};
    assign sum   = acc_q + w_ext;
    always_comb begin
        acc_sat = sum;
        if ((acc_q[WIDTH-1] == w_ext[WIDTH-1]) && (sum[WIDTH-1] != acc_q[WIDTH-1]))
            acc_sat = acc_q[WIDTH-1] ? ACC_MIN : ACC_MAX;
    end

    always_comb begin
        state_d = state_q;
        spk_d   = spk_q;
        idx_d   = idx_q;
        pend_d  = w_en;
        acc_d   = acc_q;
        ni_d    = ni_q;
        valid_d = 1'b0;

        // Weight data arrives one cycle after the request. That is why a
        // pending read is absorbed in any state, including DRAIN.
        if (pend_q)
            acc_d = acc_sat;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    spk_d   = spk_vec;
                    acc_d   = bias;
                    idx_d   = '0;
                    pend_d  = 1'b0;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                idx_d = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    state_d = DRAIN;
                end
            end
            DRAIN: state_d = DONE;
            DONE: begin
                ni_d    = acc_q;
                valid_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            spk_q   <= '0;
            idx_q   <= '0;
            pend_q  <= 1'b0;
            acc_q   <= '0;
            ni_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            spk_q   <= spk_d;
            idx_q   <= idx_d;
            pend_q  <= pend_d;
            acc_q   <= acc_d;
            ni_q    <= ni_d;
            valid_q <= valid_d;
        end
    end

endmodule

// File: tb/tb_syn_accum.sv
// ----------------------------------------------------------------------------
// tb_syn_accum -- scoreboard bench for syn_accum (N_PRE=8, WIDTH=16).
// The driver pushes the expected result, the expected cycle of the valid
// pulse and the expected set of read addresses. The monitor pops one entry
// on every valid pulse and compares it.
// ----------------------------------------------------------------------------
module tb_syn_accum;

    localparam int N_PRE = 8;
    localparam int AW    = 3;
    localparam int WW    = 8;
    localparam int W     = 16;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 start = 1'b0;
    logic [N_PRE-1:0]     spk_vec = '0;
    logic signed [W-1:0]  bias = '0;
    logic                 w_en;
    logic [AW-1:0]        w_addr;
    logic signed [WW-1:0] w_rdata = '0;
    logic signed [W-1:0]  network_input;
    logic                 valid;
    logic                 busy;

    syn_accum #(.N_PRE(N_PRE), .ADDR_WIDTH(AW), .W_WIDTH(WW), .WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .spk_vec(spk_vec), .bias(bias),
        .w_en(w_en), .w_addr(w_addr), .w_rdata(w_rdata),
        .network_input(network_input), .valid(valid), .busy(busy)
    );

    always #5 clk = ~clk;

    // Weight memory: one-cycle read latency.
    logic signed [WW-1:0] wmem [N_PRE];
    always @(posedge clk) if (w_en) w_rdata <= wmem[w_addr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         ni;
        int         at;
        logic [7:0] mask;
    } exp_t;
    exp_t sb[$];

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: the w_en address set is collected per run and compared on valid.
    logic [7:0] seen = '0;
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                seen = '0;
            end else begin
                if (w_en) seen[w_addr] = 1'b1;
                if (valid) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_valid", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        chk("network_input", int'(network_input), e.ni);
                        chk("valid_cycle", cyc, e.at);
                        chk("w_en_addrs", int'(seen), int'(e.mask));
                    end
                    seen = '0;
                end
            end
        end
    end

    task automatic wait_drain();
        for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            chk("drain_timeout", sb.size(), 0);
            sb.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic run(input logic [7:0] s, input int b, input int e, input logic [7:0] m);
        @(negedge clk);
        spk_vec = s;
        bias    = W'(b);
        start   = 1'b1;
        sb.push_back('{ni: e, at: cyc + 11, mask: m});
        @(negedge clk);
        start = 1'b0;
        wait_drain();
    endtask

    task automatic set_w(input int mode, input int v);
        for (int i = 0; i < N_PRE; i++) wmem[i] = (mode == 0) ? WW'(i + 1) : WW'(v);
    endtask

    initial begin
        int c;
        set_w(0, 0);
        repeat (2) @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_valid", int'(valid), 0);
        chk("rst_ni", int'(network_input), 0);
        chk("rst_w_en", int'(w_en), 0);
        chk("rst_w_addr", int'(w_addr), 0);
        rst = 1'b1;

        // No spikes: bias passes straight through.
        run(8'h00, 5, 5, 8'h00);
        // Inputs 0, 2 and 7: 1 + 3 + 8.
        run(8'h85, 0, 12, 8'h85);
        // Saturation in both directions.
        set_w(1, -128);
        run(8'hFF, -32700, -32768, 8'hFF);
        set_w(1, 127);
        run(8'hFF, 32700, 32767, 8'hFF);
        set_w(0, 0);

        // A start re-pulsed during SCAN with new inputs must not disturb the run.
        @(negedge clk);
        spk_vec = 8'h01; bias = '0; start = 1'b1;
        sb.push_back('{ni: 1, at: cyc + 11, mask: 8'h01});
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        spk_vec = 8'hFF; bias = 16'sd999; start = 1'b1;
        repeat (2) @(negedge clk);
        start = 1'b0;
        wait_drain();

        // Reset while idx = 4 aborts the run without a valid pulse.
        @(negedge clk);
        spk_vec = 8'hFF; bias = '0; start = 1'b1;
        c = cyc;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_valid", int'(valid), 0);
        chk("midrst_ni", int'(network_input), 0);
        chk("midrst_w_en", int'(w_en), 0);
        chk("midrst_cycle", cyc - c, 6);
        run(8'h03, 0, 3, 8'h03);

        // Back-to-back runs with start held high through the first valid.
        @(negedge clk);
        spk_vec = 8'h03; bias = '0; start = 1'b1;
        c = cyc;
        sb.push_back('{ni: 3, at: c + 11, mask: 8'h03});
        sb.push_back('{ni: 105, at: c + 22, mask: 8'h10});
        repeat (11) @(negedge clk);
        spk_vec = 8'h10; bias = 16'sd100;
        @(negedge clk);
        start = 1'b0;
        wait_drain();

        repeat (15) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
